clkdiv_phi2_gen: RTL and testbench

- Parametrised single-clock CPU phase generator. It derives a registered PHI2 clock and cycle-boundary enables from the fast clock, hsclk_in.
- Divide ratio is programmable at run time and changes only at a cycle boundary, so PHI2 never glitches.
- Provides PHI2-high cycle stretching for slow-device accesses.
- Sits between the board oscillator and the CPU clock mux. It supersedes the fixed div1/div2/div4 dividers.

---
 rtl/clkdiv_pkg.sv | 13 +
 rtl/clkdiv_phase_cnt.sv | 32 +++
 rtl/clkdiv_phi2_gen.sv | 157 +++++++++++++++
 tb/tb_clkdiv_phi2_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and default configuration for the PHI2 phase generator.
package clkdiv_pkg;
  localparam int DIV_W_DEF       = 4;
  localparam int CNT_W_DEF       = 16;
  localparam int RESET_DIV_DEF   = 7;
  localparam int STRETCH_MAX_DEF = 255;

  typedef enum logic [1:0] {
    PH1 = 2'd0,
    PH2 = 2'd1,
    STR = 2'd2
  } phase_t;
endpackage

// File: rtl/clkdiv_phase_cnt.sv
// Loadable down-counter with zero detect, used to time each PHI2 phase.
// Latency: load/decrement take effect at the next edge; zero is combinational.
// Backpressure: none; dec at zero holds the count at zero.
module clkdiv_phase_cnt #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         hsclk_in,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) cnt_q <= RST_VAL;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/clkdiv_phi2_gen.sv
// Programmable PHI2 generator; build with CLKDIV_STRETCH_EN to add PHI2-high stretching.
// Latency: phi2_q is registered; ratio changes land only on the falling boundary edge.
// Backpressure: div_req is held until div_ack; stretch_req holds PHI2 high up to STRETCH_MAX cycles.
module clkdiv_phi2_gen
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int RESET_DIV   = RESET_DIV_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int STRETCH_MAX = STRETCH_MAX_DEF
) (
  input  logic             hsclk_in,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_sel,
  input  logic             div_req,
  output logic             div_ack,
  input  logic             stretch_req,
  output logic             stretch_active,
  output logic             stretch_timeout,
  output logic             phi2_q,
  output logic             rise_en,
  output logic             fall_en,
  output logic [DIV_W-1:0] active_div,
  output logic [CNT_W-1:0] cycle_count
);
  phase_t             state_q, state_d;
  logic               phi2_d;
  logic [DIV_W-1:0]   active_div_q, active_div_d;
  logic               div_ack_q, div_ack_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [DIV_W-1:0]   cnt_load_val;
  logic               stretch_hold;
  logic               stretch_done;

  clkdiv_phase_cnt #(
    .W       (DIV_W),
    .RST_VAL (DIV_W'(RESET_DIV))
  ) u_phase_cnt (
    .hsclk_in (hsclk_in),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

`ifdef CLKDIV_STRETCH_EN
  localparam int SCNT_W = (STRETCH_MAX > 1) ? $clog2(STRETCH_MAX) : 1;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              stretch_active_q, stretch_active_d;
  logic              stretch_timeout_q, stretch_timeout_d;

  assign stretch_hold = stretch_req;
  // Release when the requester lets go or the stretch budget is spent.
  assign stretch_done = !stretch_req || (scnt_q == SCNT_W'(STRETCH_MAX - 1));

  always_comb begin
    scnt_d            = '0;
    stretch_active_d  = (state_d == STR);
    stretch_timeout_d = stretch_timeout_q;
    if (state_q == STR) begin
      scnt_d = scnt_q + SCNT_W'(1);
      if (fall_en && stretch_req) stretch_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      scnt_q            <= '0;
      stretch_active_q  <= 1'b0;
      stretch_timeout_q <= 1'b0;
    end else begin
      scnt_q            <= scnt_d;
      stretch_active_q  <= stretch_active_d;
      stretch_timeout_q <= stretch_timeout_d;
    end
  end

  assign stretch_active  = stretch_active_q;
  assign stretch_timeout = stretch_timeout_q;
`else
  logic unused_stretch;
  assign unused_stretch  = stretch_req ^ (STRETCH_MAX == 0);
  assign stretch_hold    = 1'b0;
  assign stretch_done    = 1'b1;
  assign stretch_active  = 1'b0;
  assign stretch_timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    phi2_d        = phi2_q;
    rise_en       = 1'b0;
    fall_en       = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    cnt_load_val  = active_div_q;
    active_div_d  = active_div_q;
    div_ack_d     = 1'b0;
    cycle_count_d = cycle_count_q;
    case (state_q)
      PH1: begin
        if (cnt_zero) begin
          rise_en  = 1'b1;
          state_d  = PH2;
          phi2_d   = 1'b1;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      PH2: begin
        if (!cnt_zero)         cnt_dec = 1'b1;
        else if (stretch_hold) state_d = STR;
        else                   fall_en = 1'b1;
      end
      STR: begin
        if (stretch_done) fall_en = 1'b1;
      end
      default: state_d = PH1;
    endcase

    // Cycle boundary: the only point where the ratio may change.
    if (fall_en) begin
      state_d       = PH1;
      phi2_d        = 1'b0;
      cycle_count_d = cycle_count_q + CNT_W'(1);
      cnt_load      = 1'b1;
      if (div_req) begin
        cnt_load_val = div_sel;
        active_div_d = div_sel;
        div_ack_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      state_q       <= PH1;
      phi2_q        <= 1'b0;
      active_div_q  <= DIV_W'(RESET_DIV);
      div_ack_q     <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      phi2_q        <= phi2_d;
      active_div_q  <= active_div_d;
      div_ack_q     <= div_ack_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign active_div  = active_div_q;
  assign div_ack     = div_ack_q;
  assign cycle_count = cycle_count_q;
endmodule

// File: tb/tb_clkdiv_phi2_gen.sv
// Directed bench for clkdiv_phi2_gen: phase lengths, ratio handshake, stretch and reset abort.
module tb_clkdiv_phi2_gen;
  localparam int SMAX = 8;

  logic        hsclk_in = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  div_sel = 4'd0;
  logic        div_req = 1'b0;
  logic        stretch_req = 1'b0;
  logic        div_ack, stretch_active, stretch_timeout, phi2_q, rise_en, fall_en;
  logic [3:0]  active_div;
  logic [15:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  clkdiv_phi2_gen #(
    .DIV_W       (4),
    .RESET_DIV   (7),
    .CNT_W       (16),
    .STRETCH_MAX (SMAX)
  ) dut (
    .hsclk_in        (hsclk_in),
    .rst             (rst),
    .div_sel         (div_sel),
    .div_req         (div_req),
    .div_ack         (div_ack),
    .stretch_req     (stretch_req),
    .stretch_active  (stretch_active),
    .stretch_timeout (stretch_timeout),
    .phi2_q          (phi2_q),
    .rise_en         (rise_en),
    .fall_en         (fall_en),
    .active_div      (active_div),
    .cycle_count     (cycle_count)
  );

  always #5 hsclk_in = ~hsclk_in;

  task automatic step();
    @(posedge hsclk_in);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called in the first cycle of a phase; measures its length and checks the edge enable
  // fires exactly once, in the phase's last cycle.
  task automatic phase_len(input logic lvl, input int exp_len, input string tag);
    int   n;
    int   en_n;
    logic en_last;
    n = 0;
    en_n = 0;
    en_last = 1'b0;
    while ((phi2_q === lvl) && (n < 100)) begin
      en_last = lvl ? fall_en : rise_en;
      if (en_last) en_n++;
      n++;
      step();
    end
    check_val({tag, "_len"}, n, exp_len);
    check_val({tag, "_en_cnt"}, en_n, 1);
    check_val({tag, "_en_last"}, {31'd0, en_last}, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_phi2"}, {31'd0, phi2_q}, 0);
    check_val({tag, "_active_div"}, {28'd0, active_div}, 7);
    check_val({tag, "_div_ack"}, {31'd0, div_ack}, 0);
    check_val({tag, "_str_act"}, {31'd0, stretch_active}, 0);
    check_val({tag, "_str_to"}, {31'd0, stretch_timeout}, 0);
    check_val({tag, "_cc"}, {16'd0, cycle_count}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    step();
    step();
    check_reset_state("rst");
    check_val("rst_rise_en", {31'd0, rise_en}, 0);
    check_val("rst_fall_en", {31'd0, fall_en}, 0);

    // Reset ratio: 8 low / 8 high.
    rst = 1'b0;
    phase_len(1'b0, 8, "r7_ph1a");
    phase_len(1'b1, 8, "r7_ph2a");
    check_val("r7_cc1", {16'd0, cycle_count}, 1);
    phase_len(1'b0, 8, "r7_ph1b");
    phase_len(1'b1, 8, "r7_ph2b");
    check_val("r7_cc2", {16'd0, cycle_count}, 2);

    // Ratio change to 0 requested mid-PH1 (cnt=4): 5 + 8 cycles to the boundary.
    repeat (3) step();
    div_sel = 4'd0;
    div_req = 1'b1;
    n = 0;
    while (!div_ack && (n < 40)) begin
      step();
      n++;
    end
    check_val("d0_ack_lat", n, 13);
    check_val("d0_active", {28'd0, active_div}, 0);
    check_val("d0_cc", {16'd0, cycle_count}, 3);
    check_val("d0_phi2", {31'd0, phi2_q}, 0);
    check_val("d0_rise_en", {31'd0, rise_en}, 1);
    div_req = 1'b0;
    phase_len(1'b0, 1, "d0_ph1a");
    check_val("d0_ack_pulse", {31'd0, div_ack}, 0);
    phase_len(1'b1, 1, "d0_ph2a");
    phase_len(1'b0, 1, "d0_ph1b");
    phase_len(1'b1, 1, "d0_ph2b");
    check_val("d0_cc2", {16'd0, cycle_count}, 5);

    // Request first raised in the fall_en cycle is taken on that edge.
    n = 0;
    while (!fall_en && (n < 10)) begin
      step();
      n++;
    end
    check_val("d3_fall_seen", {31'd0, fall_en}, 1);
    div_sel = 4'd3;
    div_req = 1'b1;
    step();
    check_val("d3_ack", {31'd0, div_ack}, 1);
    check_val("d3_active", {28'd0, active_div}, 3);
    check_val("d3_cc", {16'd0, cycle_count}, 6);
    div_req = 1'b0;
    phase_len(1'b0, 4, "d3_ph1");
    phase_len(1'b1, 4, "d3_ph2");
    check_val("d3_cc2", {16'd0, cycle_count}, 7);
    check_val("d3_ack_gone", {31'd0, div_ack}, 0);

`ifdef CLKDIV_STRETCH_EN
    // Stretch: high for 4 + 5 + 1 cycles, one CPU cycle counted.
    phase_len(1'b0, 4, "s_ph1");
    stretch_req = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 3) check_val("s_pre_str", {31'd0, stretch_active}, 0);
      if (i == 4) check_val("s_str_act", {31'd0, stretch_active}, 1);
    end
    check_val("s_hold_phi2", {31'd0, phi2_q}, 1);
    check_val("s_hold_fall", {31'd0, fall_en}, 0);
    stretch_req = 1'b0;
    #1;
    check_val("s_rel_fall", {31'd0, fall_en}, 1);
    step();
    check_val("s_phi2_low", {31'd0, phi2_q}, 0);
    check_val("s_act_clr", {31'd0, stretch_active}, 0);
    check_val("s_cc", {16'd0, cycle_count}, 8);
    check_val("s_no_to", {31'd0, stretch_timeout}, 0);

    // Held stretch is forced off after SMAX STR cycles; timeout is sticky.
    phase_len(1'b0, 4, "t_ph1");
    stretch_req = 1'b1;
    phase_len(1'b1, 4 + SMAX, "t_hi");
    check_val("t_timeout", {31'd0, stretch_timeout}, 1);
    check_val("t_act_clr", {31'd0, stretch_active}, 0);
    check_val("t_cc", {16'd0, cycle_count}, 9);
    stretch_req = 1'b0;
    phase_len(1'b0, 4, "t_ph1b");
    check_val("t_sticky", {31'd0, stretch_timeout}, 1);

    // Reset in the middle of a stretch with a ratio request pending.
    stretch_req = 1'b1;
    div_sel = 4'd2;
    div_req = 1'b1;
    repeat (6) step();
    check_val("a_in_str", {31'd0, stretch_active}, 1);
`else
    // Stretch logic absent: stretch_req has no effect.
    phase_len(1'b0, 4, "n_ph1");
    stretch_req = 1'b1;
    phase_len(1'b1, 4, "n_ph2");
    check_val("n_str_act", {31'd0, stretch_active}, 0);
    check_val("n_str_to", {31'd0, stretch_timeout}, 0);
    check_val("n_cc", {16'd0, cycle_count}, 8);
    stretch_req = 1'b0;
    phase_len(1'b0, 4, "n_ph1b");

    // Reset mid-PH2 with a ratio request pending.
    div_sel = 4'd2;
    div_req = 1'b1;
    repeat (2) step();
    check_val("a_in_ph2", {31'd0, phi2_q}, 1);
`endif
    rst = 1'b1;
    div_req = 1'b0;
    stretch_req = 1'b0;
    #1;
    check_reset_state("abort");
    step();
    step();
    rst = 1'b0;
    phase_len(1'b0, 8, "rr_ph1");
    phase_len(1'b1, 8, "rr_ph2");
    check_val("rr_active", {28'd0, active_div}, 7);
    check_val("rr_cc", {16'd0, cycle_count}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
